// File: rtl/mac_operand_feeder.sv
// Purpose: sequences one MAC neuron evaluation: kick, lead gap, N_TAPS operand beats, then capture the result.
// Latency: start -> neuron_start 1 cycle, first tap LEAD+2 cycles; no backpressure, WAIT holds until neuron_done.
module mac_operand_feeder #(
    parameter int N_TAPS = 3,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16,
    parameter int LEAD   = 1,
    localparam int ADDR_W = (N_TAPS > 1) ? $clog2(N_TAPS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_x,
    input  logic [DATA_W-1:0] load_w,
    input  logic              start,
    input  logic              neuron_done,
    input  logic [ACC_W-1:0]  neuron_result,
    output logic              neuron_start,
    output logic [DATA_W-1:0] x_out,
    output logic [DATA_W-1:0] w_out,
    output logic              op_valid,
    output logic              op_last,
    output logic              busy,
    output logic              done,
    output logic [ACC_W-1:0]  result
);

    localparam int CNT_W = (ADDR_W > 3) ? ADDR_W : 3;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_KICK   = 3'd1,
        S_LEAD   = 3'd2,
        S_STREAM = 3'd3,
        S_WAIT   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  x_buf_q [N_TAPS];
    logic [DATA_W-1:0]  x_buf_d [N_TAPS];
    logic [DATA_W-1:0]  w_buf_q [N_TAPS];
    logic [DATA_W-1:0]  w_buf_d [N_TAPS];
    logic [ACC_W-1:0]   result_q, result_d;
    logic               done_q, done_d;
    logic               addr_ok;
    logic [ADDR_W-1:0]  tap_idx;

    assign addr_ok = ({1'b0, load_addr} < (ADDR_W+1)'(N_TAPS));
    assign tap_idx = cnt_q[ADDR_W-1:0];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        x_buf_d  = x_buf_q;
        w_buf_d  = w_buf_q;
        result_d = result_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Buffer writes are only legal here, so a same-cycle start streams the new entry.
                if (load_en && addr_ok) begin
                    x_buf_d[load_addr] = load_x;
                    w_buf_d[load_addr] = load_w;
                end
                if (start) begin
                    state_d = S_KICK;
                    cnt_d   = '0;
                end
            end
            S_KICK: begin
                cnt_d   = '0;
                state_d = (LEAD == 0) ? S_STREAM : S_LEAD;
            end
            S_LEAD: begin
                if (cnt_q == CNT_W'(LEAD - 1)) begin
                    state_d = S_STREAM;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STREAM: begin
                if (cnt_q == CNT_W'(N_TAPS - 1)) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (neuron_done) begin
                    result_d = neuron_result;
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            x_buf_q  <= '{default: '0};
            w_buf_q  <= '{default: '0};
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            x_buf_q  <= x_buf_d;
            w_buf_q  <= w_buf_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    // Operands are forced to zero outside STREAM so the neuron never accumulates stale data.
    assign neuron_start = (state_q == S_KICK);
    assign busy         = (state_q != S_IDLE);
    assign op_valid     = (state_q == S_STREAM);
    assign op_last      = op_valid && (cnt_q == CNT_W'(N_TAPS - 1));
    assign x_out        = op_valid ? x_buf_q[tap_idx] : '0;
    assign w_out        = op_valid ? w_buf_q[tap_idx] : '0;
    assign done         = done_q;
    assign result       = result_q;

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Bench for mac_operand_feeder: directed scenarios plus randomized evaluations against a tap-timeline model.
module tb_mac_operand_feeder;

    localparam int N_TAPS = 3;
    localparam int DATA_W = 8;
    localparam int ACC_W  = 16;
    localparam int LEAD   = 1;
    localparam int LAST_K = LEAD + N_TAPS + 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              load_en;
    logic [1:0]        load_addr;
    logic [DATA_W-1:0] load_x, load_w;
    logic              start;
    logic              neuron_done;
    logic [ACC_W-1:0]  neuron_result;
    logic              neuron_start;
    logic [DATA_W-1:0] x_out, w_out;
    logic              op_valid, op_last, busy, done;
    logic [ACC_W-1:0]  result;

    int n_checks = 0;
    int n_err    = 0;

    logic [DATA_W-1:0] mx [N_TAPS];
    logic [DATA_W-1:0] mw [N_TAPS];
    logic [ACC_W-1:0]  m_result;

    mac_operand_feeder #(
        .N_TAPS(N_TAPS), .DATA_W(DATA_W), .ACC_W(ACC_W), .LEAD(LEAD)
    ) dut (
        .clk(clk), .rst(rst),
        .load_en(load_en), .load_addr(load_addr), .load_x(load_x), .load_w(load_w),
        .start(start), .neuron_done(neuron_done), .neuron_result(neuron_result),
        .neuron_start(neuron_start), .x_out(x_out), .w_out(w_out),
        .op_valid(op_valid), .op_last(op_last), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int a, input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] w);
        load_en   = 1'b1;
        load_addr = 2'(a);
        load_x    = x;
        load_w    = w;
        step();
        load_en = 1'b0;
        if (a < N_TAPS) begin
            mx[a] = x;
            mw[a] = w;
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < N_TAPS; i++) begin
            mx[i] = '0;
            mw[i] = '0;
        end
        m_result = '0;
    endtask

    task automatic test_reset();
        logic [20:0] obs;
        rst = 1'b1; load_en = 0; load_addr = 0; load_x = 0; load_w = 0;
        start = 0; neuron_done = 0; neuron_result = 0;
        step();
        step();
        rst = 1'b0;
        clear_model();
        for (int c = 0; c < 5; c++) begin
            step();
            obs = {neuron_start, op_valid, op_last, busy, done, x_out, w_out};
            n_checks++;
            if (obs !== 21'h0 || result !== 16'h0) begin
                n_err++;
                $display("FAIL reset_idle cyc=%0d got outs=%h result=%h want 0", c, obs, result);
            end
        end
    endtask

    task automatic test_basic_stream();
        int t;
        logic v;
        logic [20:0] obs, expv;
        load(0, 8'sd2, 8'sd3);
        load(1, -8'sd4, 8'sd5);
        load(2, 8'sd7, -8'sd1);
        start = 1'b1;
        for (int k = 1; k <= LAST_K; k++) begin
            step();
            start = 1'b0;
            t = k - 2 - LEAD;
            v = (t >= 0 && t < N_TAPS);
            expv = {k == 1, v, v && t == N_TAPS - 1, 1'b1, 1'b0,
                    v ? mx[t] : 8'h0, v ? mw[t] : 8'h0};
            obs = {neuron_start, op_valid, op_last, busy, done, x_out, w_out};
            n_checks++;
            if (obs !== expv) begin
                n_err++;
                $display("FAIL basic_stream C%0d got %h want %h", k, obs, expv);
            end
        end
    endtask

    task automatic test_completion();
        neuron_done = 1'b1; neuron_result = 16'sd0;
        step();
        neuron_done = 1'b0;
        n_checks++;
        if ({done, busy} !== 2'b10 || result !== 16'd0) begin
            n_err++;
            $display("FAIL completion_zero got done=%b busy=%b result=%h want 1 0 0000", done, busy, result);
        end
        start = 1'b1;
        for (int k = 1; k <= LAST_K; k++) begin
            step();
            start = 1'b0;
        end
        neuron_done = 1'b1; neuron_result = 16'sd300;
        step();
        neuron_done = 1'b0;
        m_result = 16'sd300;
        n_checks++;
        if ({done, busy} !== 2'b10 || result !== m_result) begin
            n_err++;
            $display("FAIL completion_300 got done=%b busy=%b result=%h want 1 0 %h", done, busy, result, m_result);
        end
        for (int c = 0; c < 3; c++) begin
            step();
            n_checks++;
            if (done !== 1'b0 || result !== m_result) begin
                n_err++;
                $display("FAIL result_hold cyc=%0d got done=%b result=%h want 0 %h", c, done, result, m_result);
            end
        end
    endtask

    task automatic test_ignored();
        int t;
        logic v;
        logic [20:0] obs, expv;
        load(3, 8'hAA, 8'hBB);
        start = 1'b1;
        for (int k = 1; k <= LAST_K; k++) begin
            step();
            start = 1'b0;
            t = k - 2 - LEAD;
            v = (t >= 0 && t < N_TAPS);
            expv = {k == 1, v, v && t == N_TAPS - 1, 1'b1, 1'b0,
                    v ? mx[t] : 8'h0, v ? mw[t] : 8'h0};
            obs = {neuron_start, op_valid, op_last, busy, done, x_out, w_out};
            n_checks++;
            if (obs !== expv) begin
                n_err++;
                $display("FAIL ignored_stream C%0d got %h want %h", k, obs, expv);
            end
            if (k == LEAD + 2) begin
                start = 1'b1; neuron_done = 1'b1; neuron_result = 16'h1234;
            end
            if (k == LEAD + 3) begin
                start = 1'b0; neuron_done = 1'b0;
            end
        end
        load_en = 1'b1; load_addr = 2'd0; load_x = 8'h55; load_w = 8'h66;
        for (int c = 0; c < 3; c++) begin
            step();
            n_checks++;
            if ({neuron_start, busy, done, op_valid} !== 4'b0100 || result !== m_result) begin
                n_err++;
                $display("FAIL ignored_wait cyc=%0d got ns/busy/done/vld=%b result=%h want 0100 %h",
                         c, {neuron_start, busy, done, op_valid}, result, m_result);
            end
        end
        load_en = 1'b0;
        neuron_done = 1'b1; neuron_result = 16'hFF85;
        step();
        neuron_done = 1'b0;
        m_result = 16'hFF85;
        n_checks++;
        if (done !== 1'b1 || result !== m_result) begin
            n_err++;
            $display("FAIL ignored_done got done=%b result=%h want 1 %h", done, result, m_result);
        end
    endtask

    task automatic test_back_to_back();
        int t;
        logic v;
        logic [20:0] obs, expv;
        load_en = 1'b1; load_addr = 2'd0; load_x = 8'd9; load_w = 8'd9;
        start = 1'b1;
        mx[0] = 8'd9; mw[0] = 8'd9;
        for (int k = 1; k <= LAST_K; k++) begin
            step();
            start = 1'b0; load_en = 1'b0;
            t = k - 2 - LEAD;
            v = (t >= 0 && t < N_TAPS);
            expv = {k == 1, v, v && t == N_TAPS - 1, 1'b1, 1'b0,
                    v ? mx[t] : 8'h0, v ? mw[t] : 8'h0};
            obs = {neuron_start, op_valid, op_last, busy, done, x_out, w_out};
            n_checks++;
            if (obs !== expv) begin
                n_err++;
                $display("FAIL back_to_back C%0d got %h want %h", k, obs, expv);
            end
        end
        neuron_done = 1'b1; neuron_result = 16'sd300;
        step();
        neuron_done = 1'b0;
        m_result = 16'sd300;
        n_checks++;
        if (done !== 1'b1 || result !== m_result) begin
            n_err++;
            $display("FAIL back_to_back_done got done=%b result=%h want 1 %h", done, result, m_result);
        end
    endtask

    task automatic test_reset_mid();
        int t;
        logic v;
        logic [20:0] obs, expv;
        start = 1'b1;
        for (int k = 1; k <= LEAD + 3; k++) begin
            step();
            start = 1'b0;
        end
        n_checks++;
        if (op_valid !== 1'b1 || x_out !== mx[1] || w_out !== mw[1]) begin
            n_err++;
            $display("FAIL reset_mid_tap1 got vld=%b x=%h w=%h want 1 %h %h", op_valid, x_out, w_out, mx[1], mw[1]);
        end
        rst = 1'b1;
        step();
        clear_model();
        obs = {neuron_start, op_valid, op_last, busy, done, x_out, w_out};
        n_checks++;
        if (obs !== 21'h0 || result !== 16'h0) begin
            n_err++;
            $display("FAIL reset_mid_clear got outs=%h result=%h want 0", obs, result);
        end
        rst = 1'b0;
        step();
        start = 1'b1;
        for (int k = 1; k <= LAST_K; k++) begin
            step();
            start = 1'b0;
            t = k - 2 - LEAD;
            v = (t >= 0 && t < N_TAPS);
            expv = {k == 1, v, v && t == N_TAPS - 1, 1'b1, 1'b0,
                    v ? mx[t] : 8'h0, v ? mw[t] : 8'h0};
            obs = {neuron_start, op_valid, op_last, busy, done, x_out, w_out};
            n_checks++;
            if (obs !== expv) begin
                n_err++;
                $display("FAIL reset_mid_zero C%0d got %h want %h", k, obs, expv);
            end
        end
        neuron_done = 1'b1; neuron_result = 16'h0042;
        step();
        neuron_done = 1'b0;
        m_result = 16'h0042;
        n_checks++;
        if (done !== 1'b1 || result !== m_result) begin
            n_err++;
            $display("FAIL reset_mid_done got done=%b result=%h want 1 %h", done, result, m_result);
        end
    endtask

    task automatic test_random();
        int t, gap;
        logic v;
        logic [20:0] obs, expv;
        for (int it = 0; it < 20; it++) begin
            for (int n = $urandom_range(0, 4); n > 0; n--)
                load($urandom_range(0, 3), 8'($urandom), 8'($urandom));
            start = 1'b1;
            for (int k = 1; k <= LAST_K; k++) begin
                step();
                start = 1'b0;
                t = k - 2 - LEAD;
                v = (t >= 0 && t < N_TAPS);
                expv = {k == 1, v, v && t == N_TAPS - 1, 1'b1, 1'b0,
                        v ? mx[t] : 8'h0, v ? mw[t] : 8'h0};
                obs = {neuron_start, op_valid, op_last, busy, done, x_out, w_out};
                n_checks++;
                if (obs !== expv) begin
                    n_err++;
                    $display("FAIL random it=%0d C%0d got %h want %h", it, k, obs, expv);
                end
            end
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                step();
                n_checks++;
                if ({busy, done, op_valid} !== 3'b100) begin
                    n_err++;
                    $display("FAIL random_wait it=%0d got busy/done/vld=%b want 100", it, {busy, done, op_valid});
                end
            end
            neuron_done = 1'b1; neuron_result = 16'($urandom);
            m_result = neuron_result;
            step();
            neuron_done = 1'b0;
            n_checks++;
            if ({done, busy} !== 2'b10 || result !== m_result) begin
                n_err++;
                $display("FAIL random_done it=%0d got done=%b busy=%b result=%h want 1 0 %h",
                         it, done, busy, result, m_result);
            end
            repeat ($urandom_range(0, 2)) step();
        end
    endtask

    initial begin
        test_reset();
        test_basic_stream();
        test_completion();
        test_ignored();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
